mem_port_arb: RTL and testbench

- Arbitrates the single data/instruction memory port between instruction fetch (IF) and the load/store path (LS).
- The LS path is driven by the execute-stage memory address and store data.
- Registers the winning request, presents it on the bus with a valid/ready handshake, and routes the single outstanding response back to its owner.
- Sits between the fetch/mem stages and the memory bus; its grant signals are the stall sources for the pipeline.

---
 rtl/mem_port_arb_pkg.sv | 16 +
 rtl/mem_port_arb_if.sv | 24 ++
 rtl/mem_port_arb_pick.sv | 23 ++
 rtl/mem_port_arb.sv | 139 +++++++++++++
 tb/tb_mem_port_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared encodings and widths for the memory port arbiter.
package mem_port_arb_pkg;
    localparam int XLEN     = 32;
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RSP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;
endpackage

// File: rtl/mem_port_arb_if.sv
// Memory bus side of the arbiter: request handshake plus the single response channel.
interface mem_port_arb_if import mem_port_arb_pkg::*; #(
    parameter int ADDR_W = XLEN,
    parameter int DATA_W = XLEN
);
    logic                  bus_valid_o;
    logic                  bus_ready_i;
    logic                  bus_we_o;
    logic [ADDR_W-1:0]     bus_addr_o;
    logic [DATA_W-1:0]     bus_wdata_o;
    logic [DATA_W/8-1:0]   bus_wstrb_o;
    logic                  bus_rsp_valid_i;
    logic [DATA_W-1:0]     bus_rdata_i;
    logic                  bus_err_i;

    modport master (
        output bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
        input  bus_ready_i, bus_rsp_valid_i, bus_rdata_i, bus_err_i
    );
    modport slave (
        input  bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
        output bus_ready_i, bus_rsp_valid_i, bus_rdata_i, bus_err_i
    );
endinterface

// File: rtl/mem_port_arb_pick.sv
// Combinational LS-priority pick with IF starvation override; also yields the next starve count.
module mem_arb_pick import mem_port_arb_pkg::*; #(
    parameter int STARVE_MAX = 4
) (
    input  logic                if_req_i,
    input  logic                ls_req_i,
    input  logic [STARVE_W-1:0] starve_cnt_i,
    output logic                any_req_o,
    output owner_e              winner_o,
    output logic [STARVE_W-1:0] starve_cnt_o
);
    logic starved;

    always_comb begin
        starved      = if_req_i && (starve_cnt_i == STARVE_W'(STARVE_MAX));
        any_req_o    = if_req_i | ls_req_i;
        winner_o     = (ls_req_i && !starved) ? OWN_LS : OWN_IF;
        starve_cnt_o = '0;
        // Only an LS win over a waiting IF ages the counter; anything else resets it.
        if (if_req_i && winner_o == OWN_LS)
            starve_cnt_o = (starve_cnt_i == '1) ? starve_cnt_i : starve_cnt_i + 1'b1;
    end
endmodule

// File: rtl/mem_port_arb.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and load/store.
module mem_port_arb import mem_port_arb_pkg::*; #(
    parameter int ADDR_W     = XLEN,
    parameter int DATA_W     = XLEN,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rsp_valid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    input  logic [DATA_W/8-1:0] ls_wstrb_i,
    output logic                ls_gnt_o,
    output logic                ls_rsp_valid_o,
    output logic [DATA_W-1:0]   ls_rdata_o,
    output logic                rsp_err_o,
    mem_port_arb_if.master      bus
);
    localparam int STRB_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                valid_q, valid_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;

    logic                any_req, gnt_any, rsp_fire;
    owner_e              pick_win;
    logic [STARVE_W-1:0] pick_starve;

    mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .if_req_i     (if_req_i),
        .ls_req_i     (ls_req_i),
        .starve_cnt_i (starve_q),
        .any_req_o    (any_req),
        .winner_o     (pick_win),
        .starve_cnt_o (pick_starve)
    );

    assign rsp_fire = (state_q == ARB_RSP) && bus.bus_rsp_valid_i;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        valid_d    = valid_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        gnt_any    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                starve_d = pick_starve;
                if (any_req) begin
                    gnt_any = 1'b1;
                    owner_d = pick_win;
                    valid_d = 1'b1;
                    state_d = ARB_REQ;
                    if (pick_win == OWN_LS) begin
                        we_d    = ls_we_i;
                        addr_d  = ls_addr_i;
                        wdata_d = ls_wdata_i;
                        wstrb_d = ls_wstrb_i;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = if_addr_i;
                        wdata_d = '0;
                        wstrb_d = '1;
                    end
                end
            end
            ARB_REQ: if (bus.bus_ready_i) begin
                valid_d = 1'b0;
                state_d = ARB_RSP;
            end
            ARB_RSP: if (bus.bus_rsp_valid_i) begin
                state_d = ARB_IDLE;
                if (owner_q == OWN_IF) if_rdata_d = bus.bus_rdata_i;
                else                   ls_rdata_d = bus.bus_rdata_i;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_IF;
            starve_q   <= '0;
            valid_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            valid_q    <= valid_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // Grants are masked by reset so a requester waiting through reset never sees a stray pulse.
    assign if_gnt_o       = rst_n_i & gnt_any & (pick_win == OWN_IF);
    assign ls_gnt_o       = rst_n_i & gnt_any & (pick_win == OWN_LS);
    assign if_rsp_valid_o = rsp_fire & (owner_q == OWN_IF);
    assign ls_rsp_valid_o = rsp_fire & (owner_q == OWN_LS);
    assign if_rdata_o     = if_rsp_valid_o ? bus.bus_rdata_i : if_rdata_q;
    assign ls_rdata_o     = ls_rsp_valid_o ? bus.bus_rdata_i : ls_rdata_q;
    assign rsp_err_o      = rsp_fire & bus.bus_err_i;

    assign bus.bus_valid_o = valid_q;
    assign bus.bus_we_o    = we_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_wdata_o = wdata_q;
    assign bus.bus_wstrb_o = wstrb_q;
endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arb;
    localparam int AW = 32, DW = 32, SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_gnt, if_rsp_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          ls_req, ls_we, ls_gnt, ls_rsp_valid, rsp_err;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rdata;
    logic [3:0]    ls_wstrb;

    int n_tests = 0, n_fail = 0;

    mem_port_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rsp_valid_o(if_rsp_valid), .if_rdata_o(if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
        .ls_wstrb_i(ls_wstrb), .ls_gnt_o(ls_gnt), .ls_rsp_valid_o(ls_rsp_valid),
        .ls_rdata_o(ls_rdata), .rsp_err_o(rsp_err), .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
        bus.bus_ready_i = 0; bus.bus_rsp_valid_i = 0; bus.bus_rdata_i = '0; bus.bus_err_i = 0;
    endtask

    task automatic test_reset();
        logic [139:0] outs;
        rst_n = 0;
        clear_inputs();
        repeat (3) cyc();
        settle();
        outs = {if_gnt, ls_gnt, if_rsp_valid, ls_rsp_valid, rsp_err, if_rdata, ls_rdata,
                bus.bus_valid_o, bus.bus_we_o, bus.bus_addr_o, bus.bus_wdata_o, bus.bus_wstrb_o};
        n_tests++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", outs); end
        cyc();
        rst_n = 1;
    endtask

    task automatic test_ls_read();
        cyc();
        ls_req = 1; ls_we = 0; ls_addr = 32'h100; ls_wstrb = 4'hF;
        settle();
        n_tests++;
        if ({if_gnt, ls_gnt} !== 2'b01) begin n_fail++; $display("FAIL lsrd_gnt: got %b want 01", {if_gnt, ls_gnt}); end
        cyc();
        ls_req = 0; bus.bus_ready_i = 1;
        settle();
        n_tests++;
        if ({bus.bus_valid_o, bus.bus_we_o, bus.bus_addr_o} !== {1'b1, 1'b0, 32'h100}) begin
            n_fail++; $display("FAIL lsrd_bus: got %b %b %h want 1 0 100", bus.bus_valid_o, bus.bus_we_o, bus.bus_addr_o);
        end
        cyc();
        bus.bus_ready_i = 0;
        settle();
        n_tests++;
        if ({bus.bus_valid_o, ls_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL lsrd_drop: got %b want 00", {bus.bus_valid_o, ls_rsp_valid}); end
        cyc();
        bus.bus_rsp_valid_i = 1; bus.bus_rdata_i = 32'hDEADBEEF; bus.bus_err_i = 0;
        settle();
        n_tests++;
        if ({ls_rsp_valid, if_rsp_valid, rsp_err, ls_rdata} !== {3'b100, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL lsrd_rsp: got %b%b%b %h want 100 deadbeef", ls_rsp_valid, if_rsp_valid, rsp_err, ls_rdata);
        end
        cyc();
        bus.bus_rsp_valid_i = 0; bus.bus_rdata_i = 32'h5555AAAA;
        settle();
        n_tests++;
        if ({ls_rsp_valid, ls_rdata, if_rdata} !== {1'b0, 32'hDEADBEEF, 32'h0}) begin
            n_fail++; $display("FAIL lsrd_hold: got %b %h %h want 0 deadbeef 0", ls_rsp_valid, ls_rdata, if_rdata);
        end
    endtask

    task automatic test_starve();
        int g = 0, n = 0, last = -1, ifs = 0, starve = 0;
        logic exp_if;
        cyc();
        if_req = 1; if_addr = 32'h1000; ls_req = 1; ls_we = 0; ls_addr = 32'h2000;
        bus.bus_ready_i = 1; bus.bus_rsp_valid_i = 1; bus.bus_rdata_i = 32'h77;
        while (g < 15 && n < 100) begin
            settle();
            if (if_gnt || ls_gnt) begin
                exp_if = (starve == SMAX);
                starve = exp_if ? 0 : starve + 1;
                if (if_gnt) ifs++;
                n_tests++;
                if ({if_gnt, ls_gnt} !== {exp_if, !exp_if}) begin
                    n_fail++; $display("FAIL starve_order grant %0d: got if=%b ls=%b want if=%b", g, if_gnt, ls_gnt, exp_if);
                end
                if (last >= 0) begin
                    n_tests++;
                    if (n - last !== 3) begin n_fail++; $display("FAIL starve_gap: got %0d want 3", n - last); end
                end
                last = n;
                g++;
            end
            cyc();
            n++;
        end
        n_tests++;
        if (g != 15 || ifs != 3) begin n_fail++; $display("FAIL starve_count: got %0d grants %0d if want 15 3", g, ifs); end
        if_req = 0; ls_req = 0;
        cyc(); cyc();
        bus.bus_ready_i = 0; bus.bus_rsp_valid_i = 0;
        cyc();
    endtask

    task automatic test_write_stall();
        cyc();
        ls_req = 1; ls_we = 1; ls_addr = 32'h40; ls_wdata = 32'h12345678; ls_wstrb = 4'h3;
        settle();
        n_tests++;
        if (ls_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b want 1", ls_gnt); end
        cyc();
        ls_req = 0; ls_wdata = '0; if_req = 1; if_addr = 32'h200;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus.bus_ready_i = 1;
            settle();
            n_tests++;
            if ({bus.bus_valid_o, bus.bus_we_o, bus.bus_addr_o, bus.bus_wdata_o, bus.bus_wstrb_o, if_gnt}
                !== {1'b1, 1'b1, 32'h40, 32'h12345678, 4'h3, 1'b0}) begin
                n_fail++; $display("FAIL wr_stable cyc %0d: got %b %b %h %h %h gnt=%b", i, bus.bus_valid_o,
                                   bus.bus_we_o, bus.bus_addr_o, bus.bus_wdata_o, bus.bus_wstrb_o, if_gnt);
            end
            cyc();
        end
        bus.bus_ready_i = 0;
        settle();
        n_tests++;
        if ({bus.bus_valid_o, if_gnt, ls_rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL wr_wait: got %b want 000", {bus.bus_valid_o, if_gnt, ls_rsp_valid}); end
        cyc();
        bus.bus_rsp_valid_i = 1;
        settle();
        n_tests++;
        if ({ls_rsp_valid, if_rsp_valid, if_gnt} !== 3'b100) begin n_fail++; $display("FAIL wr_ack: got %b want 100", {ls_rsp_valid, if_rsp_valid, if_gnt}); end
        cyc();
        bus.bus_rsp_valid_i = 0;
        settle();
        n_tests++;
        if ({if_gnt, ls_gnt} !== 2'b10) begin n_fail++; $display("FAIL wr_next_gnt: got %b want 10", {if_gnt, ls_gnt}); end
    endtask

    task automatic test_if_err();
        cyc();
        if_req = 0; bus.bus_ready_i = 1;
        settle();
        n_tests++;
        if ({bus.bus_valid_o, bus.bus_we_o, bus.bus_addr_o, bus.bus_wdata_o, bus.bus_wstrb_o}
            !== {1'b1, 1'b0, 32'h200, 32'h0, 4'hF}) begin
            n_fail++; $display("FAIL iferr_bus: got %b %b %h %h %h", bus.bus_valid_o, bus.bus_we_o, bus.bus_addr_o, bus.bus_wdata_o, bus.bus_wstrb_o);
        end
        cyc();
        bus.bus_ready_i = 0; bus.bus_rsp_valid_i = 1; bus.bus_err_i = 1; bus.bus_rdata_i = 32'hCAFEF00D;
        settle();
        n_tests++;
        if ({if_rsp_valid, rsp_err, ls_rsp_valid, if_rdata} !== {3'b110, 32'hCAFEF00D}) begin
            n_fail++; $display("FAIL iferr_rsp: got %b%b%b %h want 110 cafef00d", if_rsp_valid, rsp_err, ls_rsp_valid, if_rdata);
        end
        cyc();
        bus.bus_rsp_valid_i = 0; bus.bus_err_i = 0;
        ls_req = 1; ls_we = 0; ls_addr = 32'h300; ls_wstrb = 4'hF;
        settle();
        n_tests++;
        if ({ls_gnt, rsp_err} !== 2'b10) begin n_fail++; $display("FAIL iferr_idle: got %b want 10", {ls_gnt, rsp_err}); end
    endtask

    task automatic test_spurious();
        cyc();
        ls_req = 0; bus.bus_rsp_valid_i = 1; bus.bus_rdata_i = 32'h99;
        settle();
        n_tests++;
        if ({if_rsp_valid, ls_rsp_valid, rsp_err, bus.bus_valid_o} !== 4'b0001) begin
            n_fail++; $display("FAIL spur_req: got %b want 0001", {if_rsp_valid, ls_rsp_valid, rsp_err, bus.bus_valid_o});
        end
        cyc();
        bus.bus_rsp_valid_i = 0;
        settle();
        n_tests++;
        if ({bus.bus_valid_o, bus.bus_addr_o} !== {1'b1, 32'h300}) begin n_fail++; $display("FAIL spur_req_hold: got %b %h", bus.bus_valid_o, bus.bus_addr_o); end
        bus.bus_ready_i = 1;
        cyc();
        bus.bus_ready_i = 0; bus.bus_rsp_valid_i = 1; bus.bus_rdata_i = 32'h11;
        settle();
        n_tests++;
        if ({ls_rsp_valid, ls_rdata} !== {1'b1, 32'h11}) begin n_fail++; $display("FAIL spur_real_rsp: got %b %h want 1 11", ls_rsp_valid, ls_rdata); end
        cyc();
        bus.bus_rdata_i = 32'h22;
        settle();
        n_tests++;
        if ({if_rsp_valid, ls_rsp_valid, ls_rdata} !== {2'b00, 32'h11}) begin
            n_fail++; $display("FAIL spur_idle: got %b%b %h want 00 11", if_rsp_valid, ls_rsp_valid, ls_rdata);
        end
        cyc();
        bus.bus_rsp_valid_i = 0; ls_req = 1; ls_addr = 32'h500;
        settle();
        n_tests++;
        if (ls_gnt !== 1'b1) begin n_fail++; $display("FAIL spur_idle_gnt: got %b want 1", ls_gnt); end
        cyc();
        ls_req = 0; bus.bus_ready_i = 1;
        cyc();
        bus.bus_ready_i = 0; bus.bus_rsp_valid_i = 1;
        cyc();
        bus.bus_rsp_valid_i = 0;
    endtask

    task automatic test_reset_in_rsp();
        logic [139:0] outs;
        cyc();
        if_req = 1; if_addr = 32'h600;
        settle();
        n_tests++;
        if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL rstrsp_gnt: got %b want 1", if_gnt); end
        cyc();
        if_req = 0; bus.bus_ready_i = 1;
        cyc();
        bus.bus_ready_i = 0; ls_req = 1; ls_addr = 32'h700;
        #1 rst_n = 0;
        #1;
        outs = {if_gnt, ls_gnt, if_rsp_valid, ls_rsp_valid, rsp_err, if_rdata, ls_rdata,
                bus.bus_valid_o, bus.bus_we_o, bus.bus_addr_o, bus.bus_wdata_o, bus.bus_wstrb_o};
        n_tests++;
        if (outs !== '0) begin n_fail++; $display("FAIL rstrsp_async: got %h want 0", outs); end
        cyc();
        rst_n = 1; ls_req = 0; bus.bus_rsp_valid_i = 1; bus.bus_rdata_i = 32'hBAD;
        settle();
        n_tests++;
        if ({if_rsp_valid, ls_rsp_valid, if_rdata} !== {2'b00, 32'h0}) begin
            n_fail++; $display("FAIL rstrsp_late: got %b%b %h want 00 0", if_rsp_valid, ls_rsp_valid, if_rdata);
        end
        cyc();
        bus.bus_rsp_valid_i = 0; if_req = 1; if_addr = 32'h800;
        settle();
        n_tests++;
        if ({if_gnt, ls_gnt} !== 2'b10) begin n_fail++; $display("FAIL rstrsp_regnt: got %b want 10", {if_gnt, ls_gnt}); end
        cyc();
        if_req = 0; bus.bus_ready_i = 1;
        cyc();
        bus.bus_ready_i = 0; bus.bus_rsp_valid_i = 1; bus.bus_rdata_i = 32'h1234;
        settle();
        n_tests++;
        if ({if_rsp_valid, if_rdata} !== {1'b1, 32'h1234}) begin n_fail++; $display("FAIL rstrsp_after: got %b %h want 1 1234", if_rsp_valid, if_rdata); end
        cyc();
        bus.bus_rsp_valid_i = 0;
    endtask

    // Transaction-level model: phase 0 = free, 1 = request on bus, 2 = awaiting response.
    task automatic test_random();
        int phase = 0, starve = 0;
        logic own_ls = 0, if_taken = 0, ls_taken = 0, e_if_g, e_ls_g, fire;
        logic e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata, e_if_rd = '0, e_ls_rd = '0;
        logic [3:0] e_strb;
        rst_n = 0;
        clear_inputs();
        cyc();
        rst_n = 1;
        for (int c = 0; c < 2000; c++) begin
            cyc();
            if (!if_req || if_taken) begin
                if_req = ($urandom_range(0, 1) == 1); if_addr = $urandom;
            end else if ($urandom_range(0, 15) == 0) if_req = 0;
            if (!ls_req || ls_taken) begin
                ls_req = ($urandom_range(0, 1) == 1); ls_we = $urandom_range(0, 1) == 1;
                ls_addr = $urandom; ls_wdata = $urandom; ls_wstrb = 4'($urandom);
            end else if ($urandom_range(0, 15) == 0) ls_req = 0;
            bus.bus_ready_i = ($urandom_range(0, 1) == 1);
            bus.bus_rsp_valid_i = ($urandom_range(0, 4) < 2);
            bus.bus_err_i = $urandom_range(0, 1) == 1;
            bus.bus_rdata_i = $urandom;
            settle();
            e_ls_g = (phase == 0) && ls_req && !(if_req && starve == SMAX);
            e_if_g = (phase == 0) && if_req && !e_ls_g;
            n_tests++;
            if ({if_gnt, ls_gnt} !== {e_if_g, e_ls_g}) begin
                n_fail++; $display("FAIL rnd_gnt c%0d: got %b%b want %b%b", c, if_gnt, ls_gnt, e_if_g, e_ls_g);
            end
            n_tests++;
            if (phase == 1) begin
                if ({bus.bus_valid_o, bus.bus_we_o, bus.bus_addr_o, bus.bus_wdata_o, bus.bus_wstrb_o}
                    !== {1'b1, e_we, e_addr, e_wdata, e_strb}) begin
                    n_fail++; $display("FAIL rnd_bus c%0d: got %b %b %h %h %h want 1 %b %h %h %h", c, bus.bus_valid_o,
                        bus.bus_we_o, bus.bus_addr_o, bus.bus_wdata_o, bus.bus_wstrb_o, e_we, e_addr, e_wdata, e_strb);
                end
            end else if (bus.bus_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL rnd_valid c%0d: got %b want 0", c, bus.bus_valid_o);
            end
            fire = (phase == 2) && bus.bus_rsp_valid_i;
            if (fire && own_ls) e_ls_rd = bus.bus_rdata_i;
            if (fire && !own_ls) e_if_rd = bus.bus_rdata_i;
            n_tests++;
            if ({if_rsp_valid, ls_rsp_valid, rsp_err, if_rdata, ls_rdata}
                !== {fire && !own_ls, fire && own_ls, fire && bus.bus_err_i, e_if_rd, e_ls_rd}) begin
                n_fail++; $display("FAIL rnd_rsp c%0d: got %b%b%b %h %h want %b%b%b %h %h", c, if_rsp_valid, ls_rsp_valid,
                    rsp_err, if_rdata, ls_rdata, fire && !own_ls, fire && own_ls, fire && bus.bus_err_i, e_if_rd, e_ls_rd);
            end
            if_taken = e_if_g; ls_taken = e_ls_g;
            if (phase == 0) begin
                if (e_ls_g && if_req) starve = (starve < 15) ? starve + 1 : 15;
                else starve = 0;
                if (e_ls_g) begin
                    own_ls = 1; e_we = ls_we; e_addr = ls_addr; e_wdata = ls_wdata; e_strb = ls_wstrb; phase = 1;
                end else if (e_if_g) begin
                    own_ls = 0; e_we = 0; e_addr = if_addr; e_wdata = '0; e_strb = 4'hF; phase = 1;
                end
            end else if (phase == 1) begin
                if (bus.bus_ready_i) phase = 2;
            end else if (fire) phase = 0;
        end
    endtask

    initial begin
        test_reset();
        test_ls_read();
        test_starve();
        test_write_stall();
        test_if_err();
        test_spurious();
        test_reset_in_rsp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end
endmodule
